// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the ARMv4 control unit: sequencer states,
// decode field encodings, ALU operation codes and control bus bit positions.
package arm_ctrl_pkg;

  localparam int CTRL_W  = 13;
  localparam int INSTR_W = 20;
  localparam int FLAG_W  = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEMRD = 2'd2
  } state_t;

  // Instruction class (op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  // Data-processing commands (funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  // ImmSrc encodings
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Register number of the program counter
  localparam logic [3:0] REG_PC = 4'b1111;

  // Control bus bit positions
  localparam int B_PCSRC     = 12;
  localparam int B_MEMTOREG  = 11;
  localparam int B_MEMWRITE  = 10;
  localparam int B_ALU_HI    = 9;
  localparam int B_ALU_LO    = 6;
  localparam int B_ALUSRC    = 5;
  localparam int B_IMM_HI    = 4;
  localparam int B_IMM_LO    = 3;
  localparam int B_REGWRITE  = 2;
  localparam int B_REGSRC_HI = 1;
  localparam int B_REGSRC_LO = 0;

  // Flag positions within NZCV
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
  } dp_dec_t;

  // Map a data-processing command to its ALU operation; unsupported
  // commands come back invalid so the caller can turn them into a NOP.
  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    d.valid = 1'b1;
    d.alu   = ALU_ADD;
    case (cmd)
      CMD_ADD: d.alu = ALU_ADD;
      CMD_SUB: d.alu = ALU_SUB;
      CMD_AND: d.alu = ALU_AND;
      CMD_ORR: d.alu = ALU_ORR;
      CMD_EOR: d.alu = ALU_EOR;
      CMD_MOV: d.alu = ALU_MOV;
      CMD_CMP: d.alu = ALU_SUB;
      default: begin
        d.valid = 1'b0;
        d.alu   = ALU_ADD;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator: decides whether an instruction executes
// given its cond field and the registered NZCV flags.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[F_N];
  assign z_s = flags[F_Z];
  assign c_s = flags[F_C];
  assign v_s = flags[F_V];

  // Evaluate the condition against NZCV; 1111 never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// ARMv4 control unit: instruction decode, conditional execution, NZCV flag
// register and a FETCH/EXEC/MEMRD sequencer that covers the one-cycle read
// latency of the instruction ROM and data RAM.
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr_ctrl,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic [CTRL_W-1:0]   control,
  output logic                pc_en,
  output logic [FLAG_W-1:0]   flags_q
);

  state_t              state_r;
  state_t              next_state_s;
  logic [3:0]          cond_s;
  logic [1:0]          op_s;
  logic [5:0]          funct_s;
  logic [3:0]          rd_s;
  logic [3:0]          unused_rn_s;
  logic                cond_pass_s;
  logic [CTRL_W-1:0]   dec_ctrl_s;
  logic                is_ldr_s;
  logic                flag_upd_s;
  logic                flag_we_s;
  dp_dec_t             dp_s;

  assign cond_s      = instr_ctrl[19:16];
  assign op_s        = instr_ctrl[15:14];
  assign funct_s     = instr_ctrl[13:8];
  assign unused_rn_s = instr_ctrl[7:4];
  assign rd_s        = instr_ctrl[3:0];

  arm_cond_check u_cond (
    .cond  (cond_s),
    .flags (flags_q),
    .pass  (cond_pass_s)
  );

  // Unconditional decode of the instruction class into a raw control word
  always_comb begin
    dec_ctrl_s = 13'd0;
    is_ldr_s   = 1'b0;
    flag_upd_s = 1'b0;
    dp_s       = dp_decode(funct_s[4:1]);
    case (op_s)
      OP_DP: begin
        if (dp_s.valid) begin
          dec_ctrl_s[B_ALU_HI:B_ALU_LO] = dp_s.alu;
          dec_ctrl_s[B_ALUSRC]          = funct_s[5];
          dec_ctrl_s[B_IMM_HI:B_IMM_LO] = IMM_DP;
          dec_ctrl_s[B_REGWRITE]        = (funct_s[4:1] != CMD_CMP);
          flag_upd_s                    = funct_s[0] | (funct_s[4:1] == CMD_CMP);
        end else begin
          dec_ctrl_s = 13'd0;
        end
      end
      OP_MEM: begin
        dec_ctrl_s[B_ALU_HI:B_ALU_LO] = funct_s[3] ? ALU_ADD : ALU_SUB;
        dec_ctrl_s[B_ALUSRC]          = 1'b1;
        dec_ctrl_s[B_IMM_HI:B_IMM_LO] = IMM_MEM;
        if (funct_s[0]) begin
          dec_ctrl_s[B_MEMTOREG] = 1'b1;
          is_ldr_s               = 1'b1;
        end else begin
          dec_ctrl_s[B_MEMWRITE]  = 1'b1;
          dec_ctrl_s[B_REGSRC_HI] = 1'b1;
        end
      end
      OP_B: begin
        dec_ctrl_s[B_ALU_HI:B_ALU_LO] = ALU_ADD;
        dec_ctrl_s[B_ALUSRC]          = 1'b1;
        dec_ctrl_s[B_IMM_HI:B_IMM_LO] = IMM_BR;
        dec_ctrl_s[B_REGSRC_LO]       = 1'b1;
        dec_ctrl_s[B_PCSRC]           = 1'b1;
      end
      default: begin
        dec_ctrl_s = 13'd0;
      end
    endcase
  end

  // Per-state control output, PC enable, next state and flag write enable
  always_comb begin
    control      = 13'd0;
    pc_en        = 1'b0;
    next_state_s = FETCH;
    flag_we_s    = 1'b0;
    case (state_r)
      FETCH: begin
        control      = 13'd0;
        pc_en        = 1'b0;
        next_state_s = EXEC;
      end
      EXEC: begin
        control = dec_ctrl_s;
        if (!cond_pass_s) begin
          control[B_REGWRITE] = 1'b0;
          control[B_MEMWRITE] = 1'b0;
          control[B_PCSRC]    = 1'b0;
        end else begin
          control[B_PCSRC] = dec_ctrl_s[B_PCSRC] |
                             (dec_ctrl_s[B_REGWRITE] & (rd_s == REG_PC));
        end
        flag_we_s = cond_pass_s & flag_upd_s;
        if (cond_pass_s && is_ldr_s) begin
          pc_en        = 1'b0;
          next_state_s = MEMRD;
        end else begin
          pc_en        = 1'b1;
          next_state_s = FETCH;
        end
      end
      MEMRD: begin
        // Load data is back from RAM: write it to Rd (branching if Rd is PC)
        control              = dec_ctrl_s;
        control[B_MEMTOREG]  = 1'b1;
        control[B_REGWRITE]  = 1'b1;
        control[B_MEMWRITE]  = 1'b0;
        control[B_PCSRC]     = (rd_s == REG_PC);
        pc_en                = 1'b1;
        next_state_s         = FETCH;
      end
      default: begin
        control      = 13'd0;
        pc_en        = 1'b0;
        next_state_s = FETCH;
      end
    endcase
  end

  // Sequencer state and NZCV register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_r <= next_state_s;
      if (flag_we_s) begin
        flags_q <= alu_flags;
      end else begin
        flags_q <= flags_q;
      end
    end
  end

endmodule
